// File: rtl/eoc_trigger_sequencer.sv
// Trigger sequencer for the end-of-column readout.
// Expands 4-bit bunch-crossing commands into triggers and throttles them on column occupancy.
module eoc_trigger_sequencer #(
    parameter int NCOL       = 4,
    parameter int TAG_WIDTH  = 6,
    parameter int DROP_WIDTH = 12
) (
    input  logic                  Clk,
    input  logic                  ResetB,
    input  logic                  CmdValid,
    input  logic [3:0]            CmdPattern,
    input  logic [TAG_WIDTH-1:0]  CmdTag,
    output logic                  CmdReady,
    input  logic [NCOL*5-1:0]     ColReqIdBin,
    output logic                  TriggerOut,
    output logic [4:0]            TriggerIdGlobal,
    output logic                  TriggerDrop,
    output logic [DROP_WIDTH-1:0] DropCnt,
    output logic [4:0]            Occupancy,
    input  logic [4:0]            TagRdId,
    output logic [TAG_WIDTH+1:0]  TagRdData
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state, state_n;
    logic [3:0]             shreg;
    logic [1:0]             bit_idx;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic                   accept;
    logic                   eval;
    logic                   hit;
    logic                   room;
    logic [TAG_WIDTH+1:0]   tag_mem [32];

    // Worst-case lag over all columns, mod-32 so the ID wrap is transparent
    always_comb begin
        logic [4:0] diff;
        Occupancy = '0;
        diff      = '0;
        for (int k = 0; k < NCOL; k++) begin
            diff = TriggerIdGlobal - ColReqIdBin[5*k +: 5];
            if (diff > Occupancy) Occupancy = diff;
        end
    end

    always_comb begin
        state_n  = state;
        CmdReady = 1'b0;
        eval     = 1'b0;
        unique case (state)
            IDLE: begin
                CmdReady = 1'b1;
                if (CmdValid) state_n = SHIFT;
            end
            SHIFT: begin
                eval = 1'b1;
                if (bit_idx == 2'd3) begin
                    CmdReady = 1'b1;
                    state_n  = CmdValid ? SHIFT : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        accept = CmdValid && CmdReady;
        hit    = eval && shreg[3];
        room   = Occupancy < 5'd31;
    end

    always_ff @(posedge Clk or negedge ResetB) begin
        if (!ResetB) state <= IDLE;
        else         state <= state_n;
    end

    always_ff @(posedge Clk or negedge ResetB) begin
        if (!ResetB) begin
            shreg           <= '0;
            bit_idx         <= '0;
            tag_q           <= '0;
            TriggerOut      <= 1'b0;
            TriggerDrop     <= 1'b0;
            TriggerIdGlobal <= '0;
            DropCnt         <= '0;
            TagRdData       <= '0;
        end else begin
            if (accept) begin
                shreg   <= CmdPattern;
                tag_q   <= CmdTag;
                bit_idx <= '0;
            end else if (eval) begin
                shreg   <= {shreg[2:0], 1'b0};
                bit_idx <= bit_idx + 2'd1;
            end
            TriggerOut  <= hit && room;
            TriggerDrop <= hit && !room;
            if (hit && room) TriggerIdGlobal <= TriggerIdGlobal + 5'd1;
            if (hit && !room && DropCnt != {DROP_WIDTH{1'b1}})
                DropCnt <= DropCnt + DROP_WIDTH'(1);
            TagRdData <= tag_mem[TagRdId];
        end
    end

    // Tag storage has no reset; read above sees pre-write contents
    always_ff @(posedge Clk) begin
        if (hit && room) tag_mem[TriggerIdGlobal] <= {tag_q, bit_idx};
    end

endmodule

// File: tb/tb_eoc_trigger_sequencer.sv
// Directed testbench for eoc_trigger_sequencer.
// Each task drives one scenario and checks results against hand-derived values.
module tb_eoc_trigger_sequencer;

    logic        Clk = 1'b0;
    logic        ResetB = 1'b0;
    logic        CmdValid = 1'b0;
    logic [3:0]  CmdPattern = '0;
    logic [5:0]  CmdTag = '0;
    logic        CmdReady;
    logic [19:0] ColReqIdBin;
    logic        TriggerOut;
    logic [4:0]  TriggerIdGlobal;
    logic        TriggerDrop;
    logic [11:0] DropCnt;
    logic [4:0]  Occupancy;
    logic [4:0]  TagRdId = '0;
    logic [7:0]  TagRdData;

    logic [19:0] col_static = '0;
    logic        track = 1'b0;
    logic [4:0]  gid_m1;
    int          checks = 0;
    int          failures = 0;
    int          trig_total = 0;
    int          drop_total = 0;
    int          occ_max = 0;

    assign gid_m1 = TriggerIdGlobal - 5'd1;
    assign ColReqIdBin = track ? {4{gid_m1}} : col_static;

    eoc_trigger_sequencer #(.NCOL(4), .TAG_WIDTH(6), .DROP_WIDTH(12)) dut (
        .Clk(Clk), .ResetB(ResetB), .CmdValid(CmdValid),
        .CmdPattern(CmdPattern), .CmdTag(CmdTag), .CmdReady(CmdReady),
        .ColReqIdBin(ColReqIdBin), .TriggerOut(TriggerOut),
        .TriggerIdGlobal(TriggerIdGlobal), .TriggerDrop(TriggerDrop),
        .DropCnt(DropCnt), .Occupancy(Occupancy),
        .TagRdId(TagRdId), .TagRdData(TagRdData)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (TriggerOut === 1'b1) trig_total++;
        if (TriggerDrop === 1'b1) drop_total++;
        if (track) begin
            if (int'(Occupancy) > occ_max) occ_max = int'(Occupancy);
        end else begin
            occ_max = 0;
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic do_reset();
        ResetB = 1'b0;
        CmdValid = 1'b0;
        track = 1'b0;
        step(2);
        ResetB = 1'b1;
        step(1);
    endtask

    task automatic issue_cmd(input logic [3:0] pat, input logic [5:0] tag);
        int waited = 0;
        while (!CmdReady && waited < 20) begin
            step(1);
            waited++;
        end
        checks++;
        if (!CmdReady) begin
            failures++;
            $display("FAIL cmd_ready_timeout got=%0b want=1", CmdReady);
        end
        CmdValid = 1'b1;
        CmdPattern = pat;
        CmdTag = tag;
        step(1);
        CmdValid = 1'b0;
    endtask

    task automatic test_reset();
        ResetB = 1'b0;
        col_static = '0;
        step(2);
        checks++;
        if ({CmdReady, TriggerOut, TriggerDrop} !== 3'b100) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=100",
                     {CmdReady, TriggerOut, TriggerDrop});
        end
        checks++;
        if (TriggerIdGlobal !== 5'd0 || DropCnt !== 12'd0 || TagRdData !== 8'd0) begin
            failures++;
            $display("FAIL reset_regs got=%0d/%0d/%0d want=0/0/0",
                     TriggerIdGlobal, DropCnt, TagRdData);
        end
        ResetB = 1'b1;
        step(1);
    endtask

    task automatic test_basic();
        logic [4:0] seen;
        logic [7:0] exp_tag [3];
        exp_tag[0] = 8'h54;
        exp_tag[1] = 8'h56;
        exp_tag[2] = 8'h57;
        do_reset();
        col_static = '0;
        issue_cmd(4'b1011, 6'h15);
        seen = '0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            seen = {seen[3:0], TriggerOut};
        end
        checks++;
        if (seen !== 5'b10110) begin
            failures++;
            $display("FAIL basic_pulses got=%b want=10110", seen);
        end
        checks++;
        if (TriggerIdGlobal !== 5'd3 || Occupancy !== 5'd3) begin
            failures++;
            $display("FAIL basic_id got=%0d occ=%0d want=3 occ=3",
                     TriggerIdGlobal, Occupancy);
        end
        for (int a = 0; a < 3; a++) begin
            TagRdId = 5'(a);
            step(1);
            checks++;
            if (TagRdData !== exp_tag[a]) begin
                failures++;
                $display("FAIL basic_tag%0d got=%h want=%h", a, TagRdData, exp_tag[a]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t0, d0;
        do_reset();
        col_static = '0;
        t0 = trig_total;
        d0 = drop_total;
        for (int c = 0; c < 9; c++) issue_cmd(4'b1111, 6'(c));
        step(6);
        checks++;
        if (TriggerIdGlobal !== 5'd31 || Occupancy !== 5'd31) begin
            failures++;
            $display("FAIL b2b_id got=%0d occ=%0d want=31 occ=31",
                     TriggerIdGlobal, Occupancy);
        end
        checks++;
        if (DropCnt !== 12'd5 || drop_total - d0 != 5) begin
            failures++;
            $display("FAIL b2b_drop got=%0d pulses=%0d want=5 pulses=5",
                     DropCnt, drop_total - d0);
        end
        checks++;
        if (trig_total - t0 != 31) begin
            failures++;
            $display("FAIL b2b_trig got=%0d want=31", trig_total - t0);
        end
    endtask

    task automatic test_wrap();
        int t0;
        do_reset();
        track = 1'b1;
        t0 = trig_total;
        for (int c = 0; c < 10; c++) issue_cmd(4'b1111, 6'h2A);
        step(6);
        checks++;
        if (TriggerIdGlobal !== 5'd8 || DropCnt !== 12'd0) begin
            failures++;
            $display("FAIL wrap_id got=%0d drop=%0d want=8 drop=0",
                     TriggerIdGlobal, DropCnt);
        end
        checks++;
        if (occ_max > 1 || trig_total - t0 != 40) begin
            failures++;
            $display("FAIL wrap_occ got=%0d trig=%0d want<=1 trig=40",
                     occ_max, trig_total - t0);
        end
        track = 1'b0;
    endtask

    task automatic test_lag();
        do_reset();
        col_static = 20'h00800;
        step(1);
        checks++;
        if (Occupancy !== 5'd30) begin
            failures++;
            $display("FAIL lag_occ0 got=%0d want=30", Occupancy);
        end
        issue_cmd(4'b1111, 6'h01);
        step(6);
        checks++;
        if (DropCnt !== 12'd3 || TriggerIdGlobal !== 5'd1 || Occupancy !== 5'd31) begin
            failures++;
            $display("FAIL lag_res got=%0d/%0d/%0d want=3/1/31",
                     DropCnt, TriggerIdGlobal, Occupancy);
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        do_reset();
        col_static = '0;
        issue_cmd(4'b1111, 6'h07);
        step(2);
        ResetB = 1'b0;
        #1;
        t0 = trig_total;
        checks++;
        if ({CmdReady, TriggerOut, TriggerDrop} !== 3'b100 ||
            TriggerIdGlobal !== 5'd0 || DropCnt !== 12'd0 || TagRdData !== 8'd0) begin
            failures++;
            $display("FAIL midrst_regs got=%b/%0d/%0d/%0d want=100/0/0/0",
                     {CmdReady, TriggerOut, TriggerDrop},
                     TriggerIdGlobal, DropCnt, TagRdData);
        end
        step(2);
        ResetB = 1'b1;
        step(4);
        checks++;
        if (trig_total != t0 || TriggerIdGlobal !== 5'd0 || CmdReady !== 1'b1) begin
            failures++;
            $display("FAIL midrst_after got=%0d/%0d/%b want=0/0/1",
                     trig_total - t0, TriggerIdGlobal, CmdReady);
        end
    endtask

    task automatic test_saturate();
        int d0;
        do_reset();
        col_static = '0;
        d0 = drop_total;
        for (int c = 0; c < 1038; c++) issue_cmd(4'b1111, 6'h3F);
        step(6);
        checks++;
        if (DropCnt !== 12'hFFF) begin
            failures++;
            $display("FAIL sat_cnt got=%h want=fff", DropCnt);
        end
        checks++;
        if (drop_total - d0 != 4121) begin
            failures++;
            $display("FAIL sat_pulses got=%0d want=4121", drop_total - d0);
        end
        d0 = drop_total;
        issue_cmd(4'b1010, 6'h00);
        step(6);
        checks++;
        if (DropCnt !== 12'hFFF || drop_total - d0 != 2) begin
            failures++;
            $display("FAIL sat_hold got=%h pulses=%0d want=fff pulses=2",
                     DropCnt, drop_total - d0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_wrap();
        test_lag();
        test_reset_mid();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eoc_trigger_sequencer.md
Name: eoc_trigger_sequencer

Overview:
- Upstream feeder for the per-column read controllers in the end-of-column logic.
- Expands each trigger command (4-bit bunch-crossing pattern) into single-cycle triggers and maintains the global trigger ID that every column read controller tracks.
- Blocks triggers that would overrun the slowest column's 31-entry window and counts each blocked trigger as a drop.
- Stores one trigger tag per global ID so downstream readout can label events.

Parameters:
- NCOL, 4, number of column read controllers served.
- TAG_WIDTH, 6, width of command tag base; stored tag is TAG_WIDTH+2 bits.
- DROP_WIDTH, 12, width of the saturating drop counter.

Ports:
- Clk  in  1  clock.
- ResetB  in  1  asynchronous active-low reset.
- CmdValid  in  1  trigger command present.
- CmdPattern  in  4  bunch-crossing pattern; bit 3 is issued first.
- CmdTag  in  TAG_WIDTH  tag base for the command.
- CmdReady  out  1  sequencer can take a command this cycle.
- ColReqIdBin  in  NCOL*5  binary request ID of each column (column k at bits [5k+4:5k]).
- TriggerOut  out  1  one-cycle pulse per accepted trigger.
- TriggerIdGlobal  out  5  binary global trigger ID.
- TriggerDrop  out  1  one-cycle pulse per blocked trigger.
- DropCnt  out  DROP_WIDTH  saturating count of blocked triggers.
- Occupancy  out  5  max over columns of (TriggerIdGlobal - ColReqIdBin[k]) mod 32.
- TagRdId  in  5  tag-memory read address.
- TagRdData  out  TAG_WIDTH+2  tag for TagRdId, registered.

Behaviour:
- Reset (ResetB low, asynchronous) drives all of the following:
  - State to IDLE, CmdReady=1, TriggerOut=0, TriggerDrop=0, TriggerIdGlobal=0, DropCnt=0, TagRdData=0.
  - Tag memory contents are don't-care after reset.
- State machine IDLE / SHIFT:
  - IDLE: CmdReady=1. A command is accepted when CmdValid&&CmdReady at a clock edge. On acceptance, CmdPattern goes into a 4-bit shift register, CmdTag is latched, the bit index is set to 0, and the state moves to SHIFT.
  - SHIFT: CmdReady=0. Each cycle the block evaluates the current MSB of the shift register, then shifts left and increments the bit index.
  - After the 4th evaluation the state returns to IDLE.
  - A command therefore occupies exactly 4 SHIFT cycles, and the next command can be accepted at the edge that ends the 4th SHIFT cycle. CmdReady returns to 1 in that cycle.
  - Pattern 0000 still spends 4 cycles in SHIFT and issues nothing.
- Evaluating a bit that is 1:
  - Accept condition: Occupancy < 31, i.e. no column is 31 behind.
  - If accepted:
    - TriggerOut=1 in the next cycle, registered.
    - TriggerIdGlobal increments at the same edge, wrapping 31->0.
    - Tag memory [old TriggerIdGlobal] is written with {CmdTag, bit index[1:0]}.
  - If blocked:
    - TriggerDrop=1 in the next cycle.
    - DropCnt increments, saturating at all-ones.
    - TriggerIdGlobal and the tag memory are unchanged.
- Evaluating a bit that is 0: no pulse and no state change other than the shift.
- Occupancy:
  - Combinational from the registered TriggerIdGlobal and ColReqIdBin.
  - Each per-column term is a 5-bit modular subtraction.
  - Columns update ColReqIdBin in the same cycle; the new values are used at the next evaluation.
- Accepted triggers per command: at most 4. The occupancy check is re-evaluated per bit with the updated TriggerIdGlobal, so a command can be partially accepted.
- Tag memory:
  - 32 x (TAG_WIDTH+2), one write port, one read port.
  - TagRdData is valid one cycle after TagRdId.
  - Simultaneous read and write to the same address returns the old data.
- Wrap-around: the ID increment from 31 to 0 is silent. Occupancy correctness relies on the modular arithmetic.
- Reset mid-SHIFT: the remaining pattern bits are discarded and no further pulses are issued.
- CmdValid while in SHIFT: the command is ignored (not latched). The source must hold CmdValid until CmdReady.

Test Plan:
- Reset, all ColReqIdBin=0, command pattern 1011 with tag 0x15:
  - TriggerOut pulses 1 and 3 cycles after the first SHIFT cycle, plus 1 cycle after that.
  - TriggerIdGlobal ends at 3.
  - Tag[0]=0x54, tag[1]=0x56, tag[2]=0x57.
- Columns frozen at ReqId 0, nine 1111 commands issued back-to-back:
  - IDs 0..30 are accepted and TriggerIdGlobal=31 (Occupancy 31).
  - The remaining 5 triggers are dropped, giving DropCnt=5 and TriggerDrop pulses.
- Columns track ReqId=Global-1 while 40 triggers are issued:
  - TriggerIdGlobal wraps to 8, Occupancy stays <=1, DropCnt=0.
- Column 2 lags at 30 behind while the others are current, pattern 1111:
  - First trigger accepted (Occupancy 31), the next three dropped.
  - DropCnt=3, TriggerIdGlobal advanced by 1.
- ResetB asserted after the 2nd SHIFT cycle of pattern 1111:
  - No further TriggerOut, all outputs at reset values, CmdReady=1 immediately.
- DropCnt preloaded near saturation via 4095+ blocked triggers:
  - DropCnt holds at 0xFFF while TriggerDrop keeps pulsing.
